// File: rtl/i2c_master_rd.sv
// I2C master for EEPROM-style random reads: addr+W, 16-bit address, Sr, addr+R, N bytes.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL during the high phase.
module i2c_master_rd #(
   parameter int QUARTER_CYCLES = 250,
   parameter int MEM_ADDR_WIDTH = 16
) (
   input  logic                      in_clk,
   input  logic                      in_rst,
   input  logic                      in_start,
   input  logic [6:0]                in_dev_addr,
   input  logic [MEM_ADDR_WIDTH-1:0] in_mem_addr,
   input  logic [7:0]                in_rd_len,
   input  logic                      in_scl,
   input  logic                      in_sda,
   output logic                      out_scl_oe,
   output logic                      out_sda_oe,
   output logic [7:0]                out_data,
   output logic                      out_data_valid,
   output logic                      out_busy,
   output logic                      out_done,
   output logic                      out_err
);

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] START   = 4'd1;
   localparam logic [3:0] ADDR_W  = 4'd2;
   localparam logic [3:0] ACK_AW  = 4'd3;
   localparam logic [3:0] MEM_HI  = 4'd4;
   localparam logic [3:0] ACK_HI  = 4'd5;
   localparam logic [3:0] MEM_LO  = 4'd6;
   localparam logic [3:0] ACK_LO  = 4'd7;
   localparam logic [3:0] RESTART = 4'd8;
   localparam logic [3:0] ADDR_R  = 4'd9;
   localparam logic [3:0] ACK_AR  = 4'd10;
   localparam logic [3:0] READ    = 4'd11;
   localparam logic [3:0] MACK    = 4'd12;
   localparam logic [3:0] STOP    = 4'd13;

   localparam int QW = $clog2(QUARTER_CYCLES);
   localparam logic [QW-1:0] Q_LAST = QW'(QUARTER_CYCLES - 1);

   logic [3:0]                state, state_n;
   logic [QW-1:0]             qcnt, qcnt_n;
   logic [4:0]                step, step_n, step_last;
   logic [6:0]                dev;
   logic [MEM_ADDR_WIDTH-1:0] maddr;
   logic [15:0]               addr16;
   logic [7:0]                cnt, cnt_n;
   logic [7:0]                shreg, shreg_n;
   logic [7:0]                tx, data_n;
   logic                      hold, qtick, last, accept;
   logic                      err_n, busy_n, done_n, valid_n;
   logic                      scl_n, sda_n;

`ifdef I2C_CLK_STRETCH_EN
   assign hold = !out_scl_oe && !in_scl;
`else
   logic unused_scl;
   assign unused_scl = in_scl;
   assign hold = 1'b0;
`endif

   assign qtick  = (qcnt == Q_LAST) && !hold;
   assign accept = (state == IDLE) && in_start && !out_done;
   assign addr16 = 16'(maddr);
   assign last   = qtick && (step == step_last);

   // step = {bit, quarter}; each state ends on its own last quarter
   always_comb begin
      unique case (state)
         START:   step_last = 5'd3;
         RESTART: step_last = 5'd5;
         STOP:    step_last = 5'd2;
         ADDR_W, MEM_HI, MEM_LO, ADDR_R, READ:
                  step_last = 5'd31;
         default: step_last = 5'd3;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      data_n  = out_data;
      valid_n = 1'b0;
      done_n  = 1'b0;
      err_n   = out_err;
      busy_n  = out_busy;
      if (hold)
         qcnt_n = qcnt;
      else if (qcnt == Q_LAST)
         qcnt_n = '0;
      else
         qcnt_n = qcnt + QW'(1);
      step_n = qtick ? step + 5'd1 : step;
      if (qtick && step[1:0] == 2'd2)
         shreg_n = {shreg[6:0], in_sda};
      unique case (state)
         IDLE: if (accept) begin
            state_n = START;
            busy_n  = 1'b1;
            err_n   = 1'b0;
            cnt_n   = in_rd_len;
         end
         START:  if (last) state_n = ADDR_W;
         ADDR_W: if (last) state_n = ACK_AW;
         ACK_AW: if (last) begin
            state_n = shreg[0] ? STOP : MEM_HI;
            err_n   = out_err | shreg[0];
         end
         MEM_HI: if (last) state_n = ACK_HI;
         ACK_HI: if (last) begin
            state_n = shreg[0] ? STOP : MEM_LO;
            err_n   = out_err | shreg[0];
         end
         MEM_LO: if (last) state_n = ACK_LO;
         ACK_LO: if (last) begin
            state_n = shreg[0] ? STOP : RESTART;
            err_n   = out_err | shreg[0];
         end
         RESTART: if (last) state_n = ADDR_R;
         ADDR_R:  if (last) state_n = ACK_AR;
         ACK_AR: if (last) begin
            state_n = shreg[0] ? STOP : READ;
            err_n   = out_err | shreg[0];
         end
         READ: if (last) begin
            state_n = MACK;
            data_n  = shreg;
            valid_n = 1'b1;
            cnt_n   = cnt - 8'd1;
         end
         MACK: if (last) state_n = (cnt == 8'd0) ? STOP : READ;
         STOP: if (last) begin
            state_n = IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
         end
         default: state_n = IDLE;
      endcase
      if (state_n != state || state == IDLE) begin
         qcnt_n = '0;
         step_n = '0;
      end
   end

   always_comb begin
      unique case (state_n)
         ADDR_W:  tx = {dev, 1'b0};
         MEM_HI:  tx = addr16[15:8];
         MEM_LO:  tx = addr16[7:0];
         default: tx = {dev, 1'b1};
      endcase
   end

   // line levels derived from next state so the oe pins are plain flops
   always_comb begin
      scl_n = ~step_n[1];
      sda_n = 1'b0;
      unique case (state_n)
         IDLE:  scl_n = 1'b0;
         START: begin
            scl_n = 1'b0;
            sda_n = step_n[1];
         end
         RESTART: begin
            scl_n = (step_n == 5'd0);
            sda_n = (step_n >= 5'd4);
         end
         STOP: begin
            scl_n = (step_n == 5'd0);
            sda_n = (step_n != 5'd2);
         end
         ADDR_W, MEM_HI, MEM_LO, ADDR_R:
            sda_n = ~tx[3'd7 - step_n[4:2]];
         MACK:  sda_n = (cnt_n != 8'd0);
         default: ;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state          <= IDLE;
         qcnt           <= '0;
         step           <= '0;
         cnt            <= '0;
         shreg          <= '0;
         dev            <= '0;
         maddr          <= '0;
         out_scl_oe     <= 1'b0;
         out_sda_oe     <= 1'b0;
         out_data       <= '0;
         out_data_valid <= 1'b0;
         out_busy       <= 1'b0;
         out_done       <= 1'b0;
         out_err        <= 1'b0;
      end else begin
         state          <= state_n;
         qcnt           <= qcnt_n;
         step           <= step_n;
         cnt            <= cnt_n;
         shreg          <= shreg_n;
         if (accept) begin
            dev   <= in_dev_addr;
            maddr <= in_mem_addr;
         end
         out_scl_oe     <= scl_n;
         out_sda_oe     <= sda_n;
         out_data       <= data_n;
         out_data_valid <= valid_n;
         out_busy       <= busy_n;
         out_done       <= done_n;
         out_err        <= err_n;
      end
   end

endmodule

// File: tb/tb_i2c_master_rd.sv
// Directed bench for i2c_master_rd with a behavioural I2C EEPROM slave at 0x50.
// Transaction lengths are checked against quarter counts computed by hand.
module tb_i2c_master_rd;

   localparam int QC = 4;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [6:0] dev;
   logic [15:0] maddr;
   logic [7:0] len;
   logic       scl_oe, sda_oe, valid, busy, done, err;
   logic [7:0] data;
   logic       s_sda = 1'b0, s_scl = 1'b0;
   logic       stretch_on = 1'b0;
   wire        scl = !(scl_oe || s_scl);
   wire        sda = !(sda_oe || s_sda);

   i2c_master_rd #(.QUARTER_CYCLES(QC), .MEM_ADDR_WIDTH(16)) dut (
      .in_clk(clk), .in_rst(rst), .in_start(start),
      .in_dev_addr(dev), .in_mem_addr(maddr), .in_rd_len(len),
      .in_scl(scl), .in_sda(sda),
      .out_scl_oe(scl_oe), .out_sda_oe(sda_oe),
      .out_data(data), .out_data_valid(valid),
      .out_busy(busy), .out_done(done), .out_err(err)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // DUT output monitor
   int vcnt = 0, dcnt = 0;
   logic [7:0] rxq[$];
   always @(negedge clk) begin
      if (valid) begin
         vcnt++;
         rxq.push_back(data);
      end
      if (done) dcnt++;
   end

   // slave memory model
   function automatic logic [7:0] mem(input logic [15:0] a);
      case (a)
         16'h1234: return 8'hAB;
         16'h1235: return 8'hCD;
         16'h0000: return 8'h5A;
         16'h0001: return 8'h3C;
         default:  return a[7:0] ^ 8'h96;
      endcase
   endfunction

   logic [7:0]  bus_q[$];
   logic        mack_q[$];
   logic [7:0]  s_sh = 8'h00, s_tx = 8'h00;
   logic [15:0] s_ptr = 16'h0000;
   logic        s_act = 1'b0, s_rx = 1'b1, s_ack = 1'b0;
   logic        s_match = 1'b0, s_rd = 1'b0, s_mack = 1'b0;
   int          s_bit = 0, s_idx = 0, s_str = 0;
   logic        pscl = 1'b1, psda = 1'b1;

   always @(negedge clk) begin
      logic c_scl, c_sda;
      c_scl = scl;
      c_sda = sda;
      if (rst) begin
         s_act = 1'b0;
         s_sda = 1'b0;
         s_scl = 1'b0;
         s_str = 0;
      end else begin
         if (s_str > 0) begin
            s_str--;
            if (s_str == 0) s_scl = 1'b0;
         end
         if (pscl && c_scl && psda && !c_sda) begin
            s_act = 1'b1; s_rx = 1'b1; s_rd = 1'b0;
            s_bit = 0; s_idx = 0; s_ack = 1'b0; s_sda = 1'b0;
         end else if (pscl && c_scl && !psda && c_sda) begin
            s_act = 1'b0;
            s_sda = 1'b0;
         end else if (s_act && !pscl && c_scl) begin
            if (s_ack) begin
               if (!s_rx) mack_q.push_back(!c_sda);
               s_mack = !c_sda;
            end else if (s_bit < 8) begin
               s_sh = {s_sh[6:0], c_sda};
               s_bit++;
            end
         end else if (s_act && pscl && !c_scl) begin
            if (s_bit == 8 && !s_ack) begin
               s_ack = 1'b1;
               if (s_rx) begin
                  bus_q.push_back(s_sh);
                  if (s_idx == 0) begin
                     s_match = (s_sh[7:1] == 7'h50);
                     s_rd    = s_sh[0];
                  end else if (s_idx == 1) s_ptr[15:8] = s_sh;
                  else if (s_idx == 2) s_ptr[7:0] = s_sh;
                  s_idx++;
                  s_sda = s_match;
               end else s_sda = 1'b0;
            end else if (s_ack) begin
               s_ack = 1'b0;
               s_bit = 0;
               if (!s_match) begin
                  s_act = 1'b0;
                  s_sda = 1'b0;
               end else if ((s_rx && s_rd) || (!s_rx && s_mack)) begin
                  if (s_rx && stretch_on) begin
                     s_str = 500;
                     s_scl = 1'b1;
                  end
                  s_rx  = 1'b0;
                  s_tx  = mem(s_ptr);
                  s_ptr = s_ptr + 16'd1;
                  s_sda = !s_tx[7];
               end else if (!s_rx) begin
                  s_act = 1'b0;
                  s_sda = 1'b0;
               end else s_sda = 1'b0;
            end else if (!s_rx) s_sda = !s_tx[3'(7 - s_bit)];
         end
      end
      pscl = c_scl;
      psda = c_sda;
   end

   task automatic cmd(input logic [6:0] d, input logic [15:0] a, input logic [7:0] l);
      @(negedge clk);
      dev = d; maddr = a; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_up", busy, 1);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", done, 1);
      chk("busy_clr", busy, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cyc, bb, br, bv, bd, bm;
      logic found;
      rst = 1'b1; start = 1'b0; dev = '0; maddr = '0; len = '0;
      repeat (3) @(negedge clk);
      chk("rst_scl", scl_oe, 0);
      chk("rst_sda", sda_oe, 0);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // two-byte read at 0x1234
      bb = bus_q.size(); br = rxq.size(); bv = vcnt; bd = dcnt; bm = mack_q.size();
      cmd(7'h50, 16'h1234, 8'd2);
      wait_done(cyc);
      chk("t1_err", err, 0);
      chk("t1_cycles", cyc, QC * (157 + 72));
      repeat (3) @(negedge clk);
      chk("t1_nbus", bus_q.size() - bb, 4);
      chk("t1_b0", bus_q[bb], 8'hA0);
      chk("t1_b1", bus_q[bb+1], 8'h12);
      chk("t1_b2", bus_q[bb+2], 8'h34);
      chk("t1_b3", bus_q[bb+3], 8'hA1);
      chk("t1_nrx", rxq.size() - br, 2);
      chk("t1_d0", rxq[br], 8'hAB);
      chk("t1_d1", rxq[br+1], 8'hCD);
      chk("t1_valid", vcnt - bv, 2);
      chk("t1_done", dcnt - bd, 1);
      chk("t1_mack0", mack_q[bm], 1);
      chk("t1_mack1", mack_q[bm+1], 0);

      // absent device: NACK on address byte
      bb = bus_q.size(); bv = vcnt; bd = dcnt;
      cmd(7'h51, 16'h1234, 8'd2);
      wait_done(cyc);
      chk("t2_err", err, 1);
      chk("t2_cycles", cyc, QC * 43);
      repeat (3) @(negedge clk);
      chk("t2_nbus", bus_q.size() - bb, 1);
      chk("t2_b0", bus_q[bb], 8'hA2);
      chk("t2_valid", vcnt - bv, 0);
      chk("t2_done", dcnt - bd, 1);
      chk("t2_err_hold", err, 1);

      // single byte at 0x0000, then back-to-back command
      br = rxq.size(); bm = mack_q.size(); bd = dcnt;
      cmd(7'h50, 16'h0000, 8'd1);
      chk("t3_err_clr", err, 0);
      wait_done(cyc);
      chk("t3_cycles", cyc, QC * (157 + 36));
      chk("t3_ptr", s_ptr, 16'h0001);
      dev = 7'h50; maddr = 16'h1235; len = 8'd1; start = 1'b1;
      @(negedge clk);
      chk("b2b_ignored", busy, 0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accept", busy, 1);
      wait_done(cyc);
      chk("b2b_cycles", cyc, QC * (157 + 36));
      repeat (3) @(negedge clk);
      chk("t3_nrx", rxq.size() - br, 2);
      chk("t3_d0", rxq[br], 8'h5A);
      chk("b2b_d0", rxq[br+1], 8'hCD);
      chk("t3_mack", mack_q[bm], 0);
      chk("t3_done", dcnt - bd, 2);

      // in_start while busy must be ignored
      bb = bus_q.size(); br = rxq.size(); bd = dcnt;
      cmd(7'h50, 16'h1235, 8'd1);
      repeat (300) @(negedge clk);
      dev = 7'h22; maddr = 16'h0000; len = 8'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      chk("t4_cycles", cyc + 301, QC * (157 + 36));
      repeat (3) @(negedge clk);
      chk("t4_nbus", bus_q.size() - bb, 4);
      chk("t4_b0", bus_q[bb], 8'hA0);
      chk("t4_b2", bus_q[bb+2], 8'h35);
      chk("t4_b3", bus_q[bb+3], 8'hA1);
      chk("t4_nrx", rxq.size() - br, 1);
      chk("t4_d0", rxq[br], 8'hCD);
      chk("t4_done", dcnt - bd, 1);

      // reset during READ bit 4
      bv = vcnt; bd = dcnt;
      cmd(7'h50, 16'h1234, 8'd2);
      found = 1'b0;
      for (int i = 0; i < 5000 && !found; i++) begin
         @(negedge clk);
         found = s_act && !s_rx && (s_bit == 4);
      end
      chk("t5_reach", found, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_scl", scl_oe, 0);
      chk("t5_sda", sda_oe, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("t5_novalid", vcnt - bv, 0);
      chk("t5_nodone", dcnt - bd, 0);
      br = rxq.size();
      cmd(7'h50, 16'h1235, 8'd1);
      wait_done(cyc);
      chk("t5_err", err, 0);
      repeat (3) @(negedge clk);
      chk("t5_nrx", rxq.size() - br, 1);
      chk("t5_d0", rxq[br], 8'hCD);

`ifdef I2C_CLK_STRETCH_EN
      // slave stretches SCL for 500 cycles at the start of READ
      br = rxq.size();
      stretch_on = 1'b1;
      cmd(7'h50, 16'h1234, 8'd2);
      wait_done(cyc);
      stretch_on = 1'b0;
      chk("t6_cycles", cyc, QC * (157 + 72) + 500 - 2 * QC);
      repeat (3) @(negedge clk);
      chk("t6_nrx", rxq.size() - br, 2);
      chk("t6_d0", rxq[br], 8'hAB);
      chk("t6_d1", rxq[br+1], 8'hCD);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_master_rd.md
Name: i2c_master_rd

Overview:
- I2C master performing EEPROM-style random reads: START, device address+W, 16-bit memory address (MSB first), repeated START, device address+R, N data bytes, STOP.
- Used as the host-side counterpart of our I2C slave memory port, and as an on-chip reader of external I2C EEPROMs.
- Drives SCL and SDA open-drain via output-enable pins only: oe=1 pulls the line low, oe=0 releases it.

Parameters:
- QUARTER_CYCLES, 250: in_clk cycles per SCL quarter-period; SCL period = 4*QUARTER_CYCLES (100 kHz at 100 MHz). Minimum 2.
- MEM_ADDR_WIDTH, 16: memory address width; sent as two bytes, upper byte first.

Ports:
- in_clk  input  1  system clock
- in_rst  input  1  synchronous reset, active-high
- in_start  input  1  one-cycle command strobe; accepted only when out_busy=0
- in_dev_addr  input  7  slave device address (e.g. 0x50)
- in_mem_addr  input  MEM_ADDR_WIDTH  start memory address
- in_rd_len  input  8  bytes to read; 0 encodes 256
- in_scl  input  1  sampled SCL line level
- in_sda  input  1  sampled SDA line level
- out_scl_oe  output  1  1 = pull SCL low
- out_sda_oe  output  1  1 = pull SDA low
- out_data  output  8  received byte
- out_data_valid  output  1  one-cycle strobe; out_data is valid in that cycle
- out_busy  output  1  transaction in progress
- out_done  output  1  one-cycle strobe at transaction end
- out_err  output  1  set on NACK; cleared on next accepted in_start

Behaviour:
- Reset (synchronous, in_rst=1 at posedge in_clk):
  - state=IDLE; out_scl_oe=0, out_sda_oe=0, out_data=0, out_data_valid=0, out_busy=0, out_done=0, out_err=0.
  - Reset mid-transaction releases both lines immediately, with no STOP generated.
- Bit timing: each bit is quarters Q0..Q3, each QUARTER_CYCLES long.
  - SCL low in Q0/Q1, released in Q2/Q3.
  - SDA changes only at the start of Q0.
  - in_sda is sampled on the last cycle of Q2.
- START: SDA released, SCL released for 2 quarters, then SDA low for 2 quarters with SCL high, then SCL low.
- Repeated START: SCL low, SDA released for 1 quarter, then SCL released for 1 quarter, then the START sequence.
- STOP: SCL low with SDA low for 1 quarter, SCL released for 1 quarter, then SDA released for 1 quarter; then IDLE.
- State sequence: IDLE -> START -> ADDR_W -> ACK_AW -> MEM_HI -> ACK_HI -> MEM_LO -> ACK_LO -> RESTART -> ADDR_R -> ACK_AR -> READ -> MACK -> (READ | STOP) -> IDLE.
- Accepting a command (IDLE, in_start=1):
  - Latch dev_addr, mem_addr and rd_len; clear out_err.
  - out_busy goes to 1 on the next cycle.
  - in_start while busy is ignored, with no side effects.
- Transmit bytes are sent MSB first:
  - ADDR_W byte = {dev_addr,0}; ADDR_R byte = {dev_addr,1}.
  - For a 1 bit, SDA is released (oe=0); for a 0 bit, oe=1.
- ACK_* slots: SDA released; sampled in_sda=1 is a NACK.
  - On NACK: set out_err, go to STOP, and send no further bytes.
- READ:
  - SDA released for 8 bits; shift-in MSB first.
  - At the end of bit 8's Q3: out_data is updated and out_data_valid pulses for 1 cycle.
  - Byte counter decrements, 8-bit with wrap, so len 0 yields 256 bytes.
- MACK:
  - Drive ACK (oe=1) if bytes remain; release (NACK) on the last byte; then STOP.
- out_done pulses 1 cycle on entry to IDLE from STOP, for both success and error; out_busy clears the same cycle.
- Back-to-back: in_start in the same cycle as out_done is ignored; the earliest acceptance is the next cycle.
- Quarter counter and bit counter reset on every state entry; no glitches on the oe outputs (registered).

Optional Feature:
- I2C_CLK_STRETCH_EN:
  - Defined: after releasing SCL at the start of Q2, the quarter counter holds until in_scl=1 is sampled (slave clock stretching). The stall is unbounded; reset is the only escape.
  - Undefined: in_scl is ignored and timing is purely counter-based.

Test Plan:
- Slave model at 0x50, memory[0x1234]=0xAB and [0x1235]=0xCD; start dev=0x50, addr=0x1234, len=2 -> bus bytes A0,12,34,A1; out_data 0xAB then 0xCD with two valid pulses; master ACKs the first byte and NACKs the second; STOP; out_done=1, out_err=0.
- No slave at 0x51; start dev=0x51 -> NACK on the first byte; STOP follows immediately; out_err=1, out_done pulse, no out_data_valid.
- len=1, addr=0x0000 -> exactly one valid pulse, master NACK, STOP; the slave's internal address advances to 0x0001.
- in_start pulsed again mid-transaction with dev=0x22 -> ignored; bus bytes unchanged; only one out_done.
- in_rst asserted during READ bit 4 -> next cycle both oe=0, busy=0, no done; a subsequent command completes correctly.
- With I2C_CLK_STRETCH_EN, the slave model holds SCL low for 500 cycles after ACK_AR -> the master waits, and data and timing after release are unchanged.
